// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory round-robin arbiter.
//   state_t   : FSM state encoding (ST_IDLE, ST_ISSUE)
//   cnt_width : width of a counter that must be able to hold the value t
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    index with highest priority this round
//   grant   out IDX_W    first set request scanning upward from rr_ptr with wrap
//   any_req out 1        at least one request set
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W:0]       sum;

    // Rotate so that bit 0 of rot is requester rr_ptr.
    assign dbl     = {req, req} >> rr_ptr;
    assign rot     = dbl[NUM_REQ-1:0];
    assign any_req = |req;

    // Scan from the far end so the closest set bit to rr_ptr is the last assignment.
    always_comb begin
        grant = '0;
        sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                grant = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// One transaction is outstanding at a time; each completion pulses req_ready_o of
// the granted requester for one cycle.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the ISSUE watchdog, which
// aborts a transaction after TIMEOUT_CYCLES stalled cycles and flags req_err_o.
// Ports:
//   clk_i, rst_i (synchronous, active-low)
//   req_valid_i/req_wr_rd_i/req_addr_i/req_wdata_i : packed requester payloads
//   req_ready_o/req_rdata_o/req_err_o              : completion back to requesters
//   mem_valid_o/mem_wr_rd_o/mem_addr_o/mem_wdata_o : request to memory
//   mem_rdata_i/mem_ready_i                        : response from memory
//   busy_o                                         : FSM not idle
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate and latch winner's payload
// ST_ISSUE | mem_valid_o high, waiting for mem_ready_i (or watchdog)
import mem_arb_pkg::*;

module mem_rr_arbiter #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 32,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic [NUM_REQ-1:0]            req_err_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    input  logic                          mem_ready_i,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_rr_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, grant_q, pick_idx;
    logic                    any_req;
    logic                    wr_rd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]        wdata_q;
    logic [WIDTH-1:0]        rdata_q;
    logic [NUM_REQ-1:0]      ready_q;
    logic                    done;
    logic                    timed_out;
    logic                    to_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid_i),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_hit) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            wr_rd_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= '0;
            if (state_q == ST_IDLE && any_req) begin
                grant_q <= pick_idx;
                wr_rd_q <= req_wr_rd_i[pick_idx];
                addr_q  <= req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata_i[pick_idx*WIDTH +: WIDTH];
            end
            if (done) begin
                ready_q[grant_q] <= 1'b1;
                rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                // A timed-out read never saw valid data, so the last value is kept.
                if (!wr_rd_q && !timed_out) begin
                    rdata_q <= mem_rdata_i;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]   to_cnt_q;
    logic [NUM_REQ-1:0] err_q;

    assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero in IDLE, so it is already clear on the first ISSUE cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            err_q <= '0;
            if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (!mem_ready_i && !to_hit) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timed_out) begin
                err_q[grant_q] <= 1'b1;
            end
        end
    end

    assign req_err_o = err_q;
`else
    assign to_hit    = 1'b0;
    assign req_err_o = '0;
`endif

    assign req_ready_o = ready_q;
    assign req_rdata_o = rdata_q;
    assign mem_valid_o = (state_q == ST_ISSUE);
    assign busy_o      = (state_q == ST_ISSUE);
    assign mem_wr_rd_o = wr_rd_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
